// File: rtl/hex_count_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : hex_count_ctrl                                                   |
// | Brief   : Run/pause/step sequencer with programmable tick divider and      |
// |           up/down hex count. Define HEX_CTRL_STEP_EN to enable step_in.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module hex_count_ctrl #(
    parameter int PERIOD_W       = 25,
    parameter int DEFAULT_PERIOD = 12000000,
    parameter int CNT_W          = 4
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                start_in,
    input  logic                stop_in,
    input  logic                step_in,
    input  logic                dir_in,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic                period_load_in,
    output logic                period_ack_out,
    output logic                tick_out,
    output logic [CNT_W-1:0]    count_out,
    output logic                wrap_out,
    output logic [1:0]          state_out
);

    localparam logic [1:0] c_idle  = 2'b00;
    localparam logic [1:0] c_run   = 2'b01;
    localparam logic [1:0] c_pause = 2'b10;
    localparam logic [1:0] c_step  = 2'b11;

    localparam logic [PERIOD_W-1:0] c_default_period = PERIOD_W'(DEFAULT_PERIOD);
    localparam logic [PERIOD_W-1:0] c_min_period     = PERIOD_W'(2);
    localparam logic [PERIOD_W-1:0] c_period_one     = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] c_period_zero    = '0;
    localparam logic [CNT_W-1:0]    c_cnt_one        = CNT_W'(1);
    localparam logic [CNT_W-1:0]    c_cnt_zero       = '0;
    localparam logic [CNT_W-1:0]    c_cnt_max        = '1;

    logic [1:0]          r_state_q,   w_state_d;
    logic [PERIOD_W-1:0] r_div_cnt_q, w_div_cnt_d;
    logic [PERIOD_W-1:0] r_period_q,  w_period_d;
    logic [CNT_W-1:0]    r_count_q,   w_count_d;
    logic                r_tick_q,    w_tick_d;
    logic                r_wrap_q,    w_wrap_d;
    logic                r_ack_q,     w_ack_d;

    logic                w_step_cmd;
    logic                w_idle_or_pause;
    logic                w_run_tick;
    logic                w_step_go;
    logic                w_load_ok;
    logic [PERIOD_W-1:0] w_period_clamped;

`ifdef HEX_CTRL_STEP_EN
    assign w_step_cmd = step_in;
`else
    assign w_step_cmd = step_in & 1'b0;
`endif

    assign w_idle_or_pause = (r_state_q == c_idle) || (r_state_q == c_pause);
    // A stop in the terminal-count cycle pauses before the tick can fire.
    assign w_run_tick = (r_state_q == c_run) && !stop_in &&
                        (r_div_cnt_q == (r_period_q - c_period_one));
    assign w_step_go  = w_idle_or_pause && w_step_cmd && !stop_in && !start_in;
    // Ack high blocks re-acceptance while the requester is still dropping its level.
    assign w_load_ok  = period_load_in && !r_ack_q && (w_idle_or_pause || w_run_tick);
    assign w_period_clamped = (period_in < c_min_period) ? c_min_period : period_in;

    // State and output registers
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state_q   <= c_idle;
            r_div_cnt_q <= c_period_zero;
            r_period_q  <= c_default_period;
            r_count_q   <= c_cnt_zero;
            r_tick_q    <= 1'b0;
            r_wrap_q    <= 1'b0;
            r_ack_q     <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_div_cnt_q <= w_div_cnt_d;
            r_period_q  <= w_period_d;
            r_count_q   <= w_count_d;
            r_tick_q    <= w_tick_d;
            r_wrap_q    <= w_wrap_d;
            r_ack_q     <= w_ack_d;
        end
    end

    // Next state: stop > start > step
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_idle: begin
                if (!stop_in) begin
                    if (start_in)        w_state_d = c_run;
                    else if (w_step_cmd) w_state_d = c_step;
                end
            end
            c_run: begin
                if (stop_in) w_state_d = c_pause;
            end
            c_pause: begin
                if (stop_in)         w_state_d = c_idle;
                else if (start_in)   w_state_d = c_run;
                else if (w_step_cmd) w_state_d = c_step;
            end
            c_step: begin
                w_state_d = c_pause;
            end
        endcase
    end

    // Divider, period, count and pulse outputs
    always_comb begin
        w_div_cnt_d = r_div_cnt_q;
        w_period_d  = r_period_q;
        w_count_d   = r_count_q;
        w_tick_d    = w_run_tick || w_step_go;
        w_wrap_d    = 1'b0;
        w_ack_d     = w_load_ok;

        case (r_state_q)
            c_idle: begin
                if (!stop_in && start_in) w_div_cnt_d = c_period_zero;
            end
            c_run: begin
                if (!stop_in) begin
                    w_div_cnt_d = w_run_tick ? c_period_zero : (r_div_cnt_q + c_period_one);
                end
            end
            c_pause: begin
                if (stop_in) begin
                    w_div_cnt_d = c_period_zero;
                    w_count_d   = c_cnt_zero;
                end
            end
            c_step: begin
                w_div_cnt_d = r_div_cnt_q;
            end
        endcase

        if (w_tick_d) begin
            if (dir_in) begin
                w_count_d = r_count_q - c_cnt_one;
                w_wrap_d  = (r_count_q == c_cnt_zero);
            end else begin
                w_count_d = r_count_q + c_cnt_one;
                w_wrap_d  = (r_count_q == c_cnt_max);
            end
        end

        if (w_load_ok) begin
            w_period_d  = w_period_clamped;
            w_div_cnt_d = c_period_zero;
        end
    end

    assign period_ack_out = r_ack_q;
    assign tick_out       = r_tick_q;
    assign count_out      = r_count_q;
    assign wrap_out       = r_wrap_q;
    assign state_out      = r_state_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_count_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_hex_count_ctrl                                                |
// | Brief   : Directed self-checking bench for hex_count_ctrl (period 4).      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_hex_count_ctrl;

    localparam int PERIOD_W = 25;
    localparam int CNT_W    = 4;
`ifdef HEX_CTRL_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic                clk_in = 1'b0;
    logic                rst_n_in = 1'b0;
    logic                start_in = 1'b0;
    logic                stop_in = 1'b0;
    logic                step_in = 1'b0;
    logic                dir_in = 1'b0;
    logic [PERIOD_W-1:0] period_in = '0;
    logic                period_load_in = 1'b0;
    logic                period_ack_out;
    logic                tick_out;
    logic [CNT_W-1:0]    count_out;
    logic                wrap_out;
    logic [1:0]          state_out;

    int checks = 0;
    int errors = 0;

    hex_count_ctrl #(
        .PERIOD_W      (PERIOD_W),
        .DEFAULT_PERIOD(4),
        .CNT_W         (CNT_W)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .start_in      (start_in),
        .stop_in       (stop_in),
        .step_in       (step_in),
        .dir_in        (dir_in),
        .period_in     (period_in),
        .period_load_in(period_load_in),
        .period_ack_out(period_ack_out),
        .tick_out      (tick_out),
        .count_out     (count_out),
        .wrap_out      (wrap_out),
        .state_out     (state_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       rst_n;
        logic       start;
        logic       stop;
        logic       step;
        logic       exp_tick;
        logic [3:0] exp_count;
        logic [1:0] exp_state;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic rst_n, input logic start, input logic stop,
                           input logic step, input logic tick, input logic [3:0] count,
                           input logic [1:0] state);
        vec_t v;
        v.rst_n = rst_n; v.start = start; v.stop = stop; v.step = step;
        v.exp_tick = tick; v.exp_count = count; v.exp_state = state;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    // Advance until tick_out is seen; n = cycles taken, -1 if budget expires.
    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tick_out && n < budget);
        if (!tick_out) n = -1;
    endtask

    initial begin
        int n;
        int ticks;

        // rst, start, stop, step | tick, count, state  (ack and wrap expected 0)
        add_vec(0, 0, 0, 0, 0, 4'h0, 2'b00);
        add_vec(1, 1, 0, 0, 0, 4'h0, 2'b01);
        add_vec(1, 0, 0, 0, 0, 4'h0, 2'b01);
        add_vec(1, 0, 0, 0, 0, 4'h0, 2'b01);
        add_vec(1, 0, 0, 0, 0, 4'h0, 2'b01);
        add_vec(1, 0, 0, 0, 1, 4'h1, 2'b01);
        add_vec(1, 0, 0, 0, 0, 4'h1, 2'b01);
        add_vec(1, 0, 0, 0, 0, 4'h1, 2'b01);
        add_vec(1, 0, 0, 0, 0, 4'h1, 2'b01);
        add_vec(1, 0, 0, 0, 1, 4'h2, 2'b01);
        add_vec(1, 0, 0, 0, 0, 4'h2, 2'b01);
        add_vec(1, 0, 0, 0, 0, 4'h2, 2'b01);
        add_vec(1, 0, 0, 0, 0, 4'h2, 2'b01);
        add_vec(1, 0, 0, 0, 1, 4'h3, 2'b01);
        add_vec(1, 1, 1, 0, 0, 4'h3, 2'b10);
        add_vec(1, 0, 1, 0, 0, 4'h0, 2'b00);
        add_vec(1, 1, 1, 0, 0, 4'h0, 2'b00);
        add_vec(1, 0, 0, 1, STEP_EN, STEP_EN ? 4'h1 : 4'h0, STEP_EN ? 2'b11 : 2'b00);
        add_vec(1, 0, 0, 0, 0, STEP_EN ? 4'h1 : 4'h0, STEP_EN ? 2'b10 : 2'b00);

        cyc();
        for (int i = 0; i < tbl.size(); i++) begin
            rst_n_in = tbl[i].rst_n;
            start_in = tbl[i].start;
            stop_in  = tbl[i].stop;
            step_in  = tbl[i].step;
            cyc();
            chk($sformatf("vec%0d", i),
                {23'd0, period_ack_out, tick_out, count_out, wrap_out, state_out},
                {23'd0, 1'b0, tbl[i].exp_tick, tbl[i].exp_count, 1'b0, tbl[i].exp_state});
        end
        rst_n_in = 1'b1; start_in = 1'b0; stop_in = 1'b0; step_in = 1'b0;

        // Period 0 loaded in IDLE clamps to 2; count up to E, wrap both directions
        rst_n_in = 1'b0; cyc(); rst_n_in = 1'b1;
        period_in = '0; period_load_in = 1'b1;
        cyc();
        chk("ack_idle", {31'd0, period_ack_out}, 32'd1);
        period_load_in = 1'b0;
        cyc();
        chk("ack_idle_drop", {31'd0, period_ack_out}, 32'd0);
        start_in = 1'b1; cyc(); start_in = 1'b0;
        for (int i = 0; i < 14; i++) begin
            wait_tick(20, n);
            chk($sformatf("gap2_%0d", i), n, 2);
        end
        chk("count_e", {28'd0, count_out}, 32'hE);
        wait_tick(20, n);
        chk("up_f", {27'd0, count_out, wrap_out}, {27'd0, 4'hF, 1'b0});
        wait_tick(20, n);
        chk("up_wrap", {27'd0, count_out, wrap_out}, {27'd0, 4'h0, 1'b1});
        dir_in = 1'b1;
        cyc();
        chk("wrap_pulse", {31'd0, wrap_out}, 32'd0);
        wait_tick(20, n);
        chk("down_wrap", {27'd0, count_out, wrap_out}, {27'd0, 4'hF, 1'b1});
        dir_in = 1'b0;

        // Pause at div_cnt=2 keeps phase; double stop clears to IDLE
        rst_n_in = 1'b0; cyc(); rst_n_in = 1'b1;
        start_in = 1'b1; cyc(); start_in = 1'b0;
        cyc(); cyc();
        stop_in = 1'b1; cyc(); stop_in = 1'b0;
        chk("pause_state", {30'd0, state_out}, 32'd2);
        ticks = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (tick_out) ticks++;
        end
        chk("pause_no_tick", ticks, 0);
        start_in = 1'b1; cyc(); start_in = 1'b0;
        wait_tick(20, n);
        chk("resume_gap", n, 2);
        chk("resume_count", {28'd0, count_out}, 32'd1);
        stop_in = 1'b1; cyc(); cyc(); stop_in = 1'b0;
        chk("stop2_idle", {26'd0, state_out, count_out}, {26'd0, 2'b00, 4'h0});

        // Period change in RUN waits for the tick; in-RUN load of 0 clamps to 2
        rst_n_in = 1'b0; cyc(); rst_n_in = 1'b1;
        start_in = 1'b1; cyc(); start_in = 1'b0;
        cyc();
        period_in = 25'd10; period_load_in = 1'b1;
        cyc();
        chk("run_noack_a", {31'd0, period_ack_out}, 32'd0);
        cyc();
        chk("run_noack_b", {31'd0, period_ack_out}, 32'd0);
        cyc();
        chk("run_ack_tick", {30'd0, tick_out, period_ack_out}, 32'd3);
        period_load_in = 1'b0;
        wait_tick(30, n);
        chk("gap10_a", n, 10);
        wait_tick(30, n);
        chk("gap10_b", n, 10);
        period_in = '0; period_load_in = 1'b1;
        wait_tick(30, n);
        chk("gap10_c", n, 10);
        chk("ack_min", {31'd0, period_ack_out}, 32'd1);
        period_load_in = 1'b0;
        wait_tick(30, n);
        chk("gapmin_a", n, 2);
        wait_tick(30, n);
        chk("gapmin_b", n, 2);

        // Reset on a tick cycle with a request pending
        cyc();
        period_in = 25'd10; period_load_in = 1'b1; rst_n_in = 1'b0;
        cyc();
        chk("rst_outs", {24'd0, period_ack_out, tick_out, count_out, state_out},
            {24'd0, 1'b0, 1'b0, 4'h0, 2'b00});
        rst_n_in = 1'b1; period_load_in = 1'b0;
        cyc();
        chk("rst_noack", {31'd0, period_ack_out}, 32'd0);
        start_in = 1'b1; cyc(); start_in = 1'b0;
        wait_tick(30, n);
        chk("rst_default_period", n, 4);

        // Step from PAUSE
        stop_in = 1'b1; cyc(); stop_in = 1'b0;
        chk("step_pause", {26'd0, state_out, count_out}, {26'd0, 2'b10, 4'h1});
        step_in = 1'b1; cyc(); step_in = 1'b0;
        chk("step_cycle", {25'd0, tick_out, state_out, count_out},
            {25'd0, STEP_EN, STEP_EN ? 2'b11 : 2'b10, STEP_EN ? 4'h2 : 4'h1});
        cyc();
        chk("step_back", {25'd0, tick_out, state_out, count_out},
            {25'd0, 1'b0, 2'b10, STEP_EN ? 4'h2 : 4'h1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
